// File: rtl/rp_adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder.
//  - RP_ADDER_DEF_WIDTH / RP_ADDER_DEF_STAGES : default configuration (32 bits, 4 stages)
//  - seg_w(width, stages)                     : bits rippled per pipeline stage
//  - stage_ctrl_t                             : per-stage control record (valid, carry out)
// The partial sum of each stage grows by one segment per stage, so it is held
// next to this record in the top rather than inside it.
package rp_adder_pkg;

  localparam int RP_ADDER_DEF_WIDTH  = 32;
  localparam int RP_ADDER_DEF_STAGES = 4;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  function automatic int seg_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/rp_adder_seg.sv
// Combinational ripple-carry segment of SEG_W bits.
// Ports:
//  a, b   in  SEG_W  operand bits of this segment
//  ci     in  1      carry into the segment LSB
//  s      out SEG_W  segment sum
//  co     out 1      carry out of the segment MSB
//  c_msb  out 1      carry into the segment MSB (only when RP_ADDER_OVF_EN is defined)
module rp_adder_seg #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co
`ifdef RP_ADDER_OVF_EN
  ,
  output logic             c_msb
`endif
);

  // c[i] is the carry into bit i; c[SEG_W] leaves the segment.
  logic [SEG_W:0] c;

  assign c[0] = ci;

  for (genvar gi = 0; gi < SEG_W; gi++) begin : g_bit
    assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign co = c[SEG_W];

`ifdef RP_ADDER_OVF_EN
  assign c_msb = c[SEG_W-1];
`endif

endmodule

// File: rtl/rp_adder_pipe.sv
// Pipelined ripple-carry adder with valid/ready handshake.
// A WIDTH-bit add is split into STAGES segments of WIDTH/STAGES bits; stage k
// ripples segment k using the registered carry of stage k-1. Higher operand
// bits ride along with the token until their stage. Latency is STAGES cycles,
// throughput one result per cycle. The whole pipe shifts when the output is
// empty or being taken, and freezes otherwise.
// Optional feature: define RP_ADDER_OVF_EN to add the registered signed-overflow
// output ovf (carry into MSB XOR carry out).
// Ports:
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      a/b/cin valid
//  in_ready   out  1      operands accepted this cycle
//  a, b       in   WIDTH  operands
//  cin        in   1      carry in
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  low WIDTH bits of a+b+cin
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow (RP_ADDER_OVF_EN only)
module rp_adder_pipe
  import rp_adder_pkg::*;
#(
  parameter int WIDTH  = RP_ADDER_DEF_WIDTH,
  parameter int STAGES = RP_ADDER_DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RP_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SEG = seg_w(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("rp_adder_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // Single shift enable for every stage; bubbles are kept in place.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar gi = 0; gi < STAGES; gi++) begin : stage
    localparam int LO     = gi * SEG;        // first bit rippled here
    localparam int SRC_W  = WIDTH - LO;      // operand bits not yet summed on entry
    localparam int PEND_W = SRC_W - SEG;     // operand bits still pending on exit

    logic [SRC_W-1:0]  src_a;
    logic [SRC_W-1:0]  src_b;
    logic              src_ci;
    logic              src_valid;
    logic [LO+SEG-1:0] psum_next;
    logic [SEG-1:0]    seg_s;
    logic              seg_co;

    logic [LO+SEG-1:0] psum_reg;
    stage_ctrl_t       ctrl_reg;

    if (gi == 0) begin : g_src
      assign src_a     = a;
      assign src_b     = b;
      assign src_ci    = cin;
      assign src_valid = in_valid;
      assign psum_next = seg_s;
    end else begin : g_src
      assign src_a     = stage[gi-1].g_pend.a_pend_reg;
      assign src_b     = stage[gi-1].g_pend.b_pend_reg;
      assign src_ci    = stage[gi-1].ctrl_reg.carry;
      assign src_valid = stage[gi-1].ctrl_reg.valid;
      assign psum_next = {seg_s, stage[gi-1].psum_reg};
    end

`ifdef RP_ADDER_OVF_EN
    logic seg_c_msb;
`endif

    rp_adder_seg #(
      .SEG_W (SEG)
    ) u_seg (
      .a     (src_a[SEG-1:0]),
      .b     (src_b[SEG-1:0]),
      .ci    (src_ci),
      .s     (seg_s),
      .co    (seg_co)
`ifdef RP_ADDER_OVF_EN
      ,
      .c_msb (seg_c_msb)
`endif
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        ctrl_reg <= '0;
        psum_reg <= '0;
      end else if (advance) begin
        ctrl_reg.valid <= src_valid;
        ctrl_reg.carry <= seg_co;
        psum_reg       <= psum_next;
      end
    end

    // Operand delay line: only the bits of later segments are carried forward.
    if (PEND_W > 0) begin : g_pend
      logic [PEND_W-1:0] a_pend_reg;
      logic [PEND_W-1:0] b_pend_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_pend_reg <= '0;
          b_pend_reg <= '0;
        end else if (advance) begin
          a_pend_reg <= src_a[SRC_W-1:SEG];
          b_pend_reg <= src_b[SRC_W-1:SEG];
        end
      end
    end

`ifdef RP_ADDER_OVF_EN
    // Only the last segment holds the MSB, so only it registers overflow.
    if (gi == STAGES - 1) begin : g_ovf
      logic ovf_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (advance) begin
          ovf_reg <= seg_c_msb ^ seg_co;
        end
      end
    end
`endif
  end

  assign sum       = stage[STAGES-1].psum_reg;
  assign cout      = stage[STAGES-1].ctrl_reg.carry;
  assign out_valid = stage[STAGES-1].ctrl_reg.valid;

`ifdef RP_ADDER_OVF_EN
  assign ovf = stage[STAGES-1].g_ovf.ovf_reg;
`endif

endmodule
